// File: rtl/iram_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : iram_mp
// Purpose : Multi-port instruction RAM with registered fetch ports, a runtime
//           load port, reset-time clear sequence and out-of-range detection.
// Revision: 1.0
// ---------------------------------------------------------------------------
module iram_mp #(
  parameter int              NPORTS    = 4,
  parameter int              AW        = 6,
  parameter int              IW        = 21,
  parameter int              DEPTH     = 52,
  parameter logic [IW-1:0]   FILL_WORD = 21'h20000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic [NPORTS-1:0]    fetch_req,
  input  logic [NPORTS*AW-1:0] fetch_pc,
  output logic [NPORTS*IW-1:0] ins_out,
  output logic [NPORTS-1:0]    ins_valid,
  output logic [NPORTS-1:0]    oob,
  input  logic                 ld_en,
  input  logic [AW-1:0]        ld_addr,
  input  logic [IW-1:0]        ld_data,
  output logic                 ld_ack,
  output logic                 ld_err
);

  localparam logic [0:0]    ST_INIT   = 1'b0;
  localparam logic [0:0]    ST_RUN    = 1'b1;
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [0:0]    state;
  logic [0:0]    state_next;
  logic [AW-1:0] cnt;
  logic [IW-1:0] mem [DEPTH];

  logic          run;
  logic          init_wr;
  logic          ld_in_range;
  logic          ld_wr;
  logic          ld_bad;

  logic [AW-1:0]     port_pc [NPORTS];
  logic [NPORTS-1:0] port_in_range;

  // State register and clear counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_INIT && cnt == LAST_ADDR) begin
      state_next = ST_RUN;
    end
  end

  always_comb begin
    ready       = (state == ST_RUN);
    run         = (state == ST_RUN);
    init_wr     = (state == ST_INIT);
    ld_in_range = ({1'b0, ld_addr} < DEPTH_W);
    ld_wr       = run && ld_en && ld_in_range;
    ld_bad      = run && ld_en && !ld_in_range;
  end

  // Reset leaves the array untouched; only INIT clears it afterwards
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_wr) begin
        mem[cnt] <= FILL_WORD;
      end else if (ld_wr) begin
        mem[ld_addr] <= ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_ack <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      ld_ack <= ld_wr;
      ld_err <= ld_bad;
    end
  end

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      assign port_pc[gi]       = fetch_pc[gi*AW +: AW];
      assign port_in_range[gi] = ({1'b0, port_pc[gi]} < DEPTH_W);
    end
  endgenerate

  // Reads sample the array before this edge's load lands (read-before-write)
  always_ff @(posedge clk) begin
    if (rst) begin
      ins_out   <= '0;
      ins_valid <= '0;
      oob       <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (run && fetch_req[i]) begin
          ins_valid[i] <= 1'b1;
          if (port_in_range[i]) begin
            ins_out[i*IW +: IW] <= mem[port_pc[i]];
            oob[i]              <= 1'b0;
          end else begin
            ins_out[i*IW +: IW] <= FILL_WORD;
            oob[i]              <= 1'b1;
          end
        end else begin
          ins_valid[i] <= 1'b0;
          oob[i]       <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iram_mp.sv
`default_nettype none
// Testbench for iram_mp: directed vector table, hand-written reset/clear
// sequences, and randomized traffic checked against a behavioural model.
module tb_iram_mp;
  localparam int          NP    = 4;
  localparam int          AW    = 6;
  localparam int          IW    = 21;
  localparam int          DEPTH = 52;
  localparam logic [20:0] FILL  = 21'h20000;
  localparam logic [20:0] VA    = 21'h0A5A5;
  localparam logic [20:0] VB    = 21'h00011;
  localparam logic [20:0] VC    = 21'h1FFFF;

  logic              clk;
  logic              rst;
  logic              ready;
  logic [NP-1:0]     fetch_req;
  logic [NP*AW-1:0]  fetch_pc;
  logic [NP*IW-1:0]  ins_out;
  logic [NP-1:0]     ins_valid;
  logic [NP-1:0]     oob;
  logic              ld_en;
  logic [AW-1:0]     ld_addr;
  logic [IW-1:0]     ld_data;
  logic              ld_ack;
  logic              ld_err;

  iram_mp dut (
    .clk(clk), .rst(rst), .ready(ready),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .ins_out(ins_out), .ins_valid(ins_valid), .oob(oob),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ack(ld_ack), .ld_err(ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: an array of words plus the last response per port
  logic [20:0]   m_mem [DEPTH];
  logic [20:0]   m_ins [NP];
  logic [NP-1:0] m_valid;
  logic [NP-1:0] m_oob;
  logic          m_ack;
  logic          m_err;
  logic          m_ready;
  int            m_cnt = 0;
  bit            m_init = 1'b0;

  task automatic model_edge();
    int pc;
    if (rst) begin
      m_init = 1'b1; m_cnt = 0; m_ready = 1'b0;
      m_valid = '0; m_oob = '0; m_ack = 1'b0; m_err = 1'b0;
      for (int i = 0; i < NP; i++) m_ins[i] = '0;
    end else if (m_init) begin
      m_mem[m_cnt] = FILL;
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_init = 1'b0; m_ready = 1'b1;
      end
      m_valid = '0; m_oob = '0; m_ack = 1'b0; m_err = 1'b0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (fetch_req[i]) begin
          pc = int'(fetch_pc[i*AW +: AW]);
          m_valid[i] = 1'b1;
          if (pc < DEPTH) begin
            m_ins[i] = m_mem[pc]; m_oob[i] = 1'b0;
          end else begin
            m_ins[i] = FILL; m_oob[i] = 1'b1;
          end
        end else begin
          m_valid[i] = 1'b0; m_oob[i] = 1'b0;
        end
      end
      m_ack = 1'b0; m_err = 1'b0;
      if (ld_en) begin
        if (int'(ld_addr) < DEPTH) begin
          m_mem[int'(ld_addr)] = ld_data; m_ack = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [NP*IW-1:0] e;
    for (int i = 0; i < NP; i++) e[i*IW +: IW] = m_ins[i];
    chk({tag, "_ins"},   ins_out,   e);
    chk({tag, "_valid"}, ins_valid, m_valid);
    chk({tag, "_oob"},   oob,       m_oob);
    chk({tag, "_ack"},   ld_ack,    m_ack);
    chk({tag, "_err"},   ld_err,    m_err);
    chk({tag, "_ready"}, ready,     m_ready);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [23:0] pc;
    logic        ld;
    logic [5:0]  addr;
    logic [20:0] data;
    logic [3:0]  valid;
    logic [3:0]  oobv;
    logic [83:0] ins;
    logic        ack;
    logic        err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    // pc fields are {port3, port2, port1, port0}; ins likewise
    vecs[0] = '{4'hF, {6'd51, 6'd33, 6'd17, 6'd0}, 1'b0, 6'd0,  21'd0, 4'hF,    4'h0,    {FILL, FILL, FILL, FILL}, 1'b0, 1'b0};
    vecs[1] = '{4'h0, 24'd0,                       1'b1, 6'd5,  VA,    4'h0,    4'h0,    {FILL, FILL, FILL, FILL}, 1'b1, 1'b0};
    vecs[2] = '{4'h9, {6'd5, 6'd0, 6'd0, 6'd5},    1'b1, 6'd7,  VB,    4'h9,    4'h0,    {VA,   FILL, FILL, VA},   1'b1, 1'b0};
    vecs[3] = '{4'h2, {6'd0, 6'd0, 6'd7, 6'd0},    1'b1, 6'd7,  VC,    4'h2,    4'h0,    {VA,   FILL, VB,   VA},   1'b1, 1'b0};
    vecs[4] = '{4'h2, {6'd0, 6'd0, 6'd7, 6'd0},    1'b0, 6'd0,  21'd0, 4'h2,    4'h0,    {VA,   FILL, VC,   VA},   1'b0, 1'b0};
    vecs[5] = '{4'h5, {6'd0, 6'd52, 6'd0, 6'd63},  1'b1, 6'd60, VC,    4'h5,    4'h5,    {VA,   FILL, VC,   FILL}, 1'b0, 1'b1};
    vecs[6] = '{4'h1, {6'd0, 6'd0, 6'd0, 6'd5},    1'b0, 6'd0,  21'd0, 4'h1,    4'h0,    {VA,   FILL, VC,   VA},   1'b0, 1'b0};
    vecs[7] = '{4'h0, {6'd0, 6'd0, 6'd0, 6'd5},    1'b0, 6'd0,  21'd0, 4'h0,    4'h0,    {VA,   FILL, VC,   VA},   1'b0, 1'b0};
    vecs[8] = '{4'hA, {6'd60, 6'd0, 6'd8, 6'd0},   1'b0, 6'd0,  21'd0, 4'hA,    4'h8,    {FILL, FILL, FILL, VA},   1'b0, 1'b0};

    rst = 1'b1; fetch_req = '0; fetch_pc = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick(); tick();
    chk("rst_ready", ready, 1'b0);
    chk("rst_ins",   ins_out, '0);
    chk("rst_valid", ins_valid, '0);
    chk("rst_oob",   oob, '0);
    chk("rst_ack",   ld_ack, 1'b0);
    chk("rst_err",   ld_err, 1'b0);

    // Clear sequence with fetches and loads offered that must be ignored
    rst = 1'b0; fetch_req = 4'hF; ld_en = 1'b1; ld_addr = 6'd3; ld_data = 21'h01234;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick(); n++;
      chk("init_valid", ins_valid, '0);
      chk("init_ack", ld_ack, 1'b0);
    end
    chk("init_latency", n, 52);
    fetch_req = '0; ld_en = 1'b0;

    for (int k = 0; k < 9; k++) begin
      fetch_req = vecs[k].req; fetch_pc = vecs[k].pc;
      ld_en = vecs[k].ld; ld_addr = vecs[k].addr; ld_data = vecs[k].data;
      tick();
      chk($sformatf("vec%0d_ins", k),   ins_out,   vecs[k].ins);
      chk($sformatf("vec%0d_valid", k), ins_valid, vecs[k].valid);
      chk($sformatf("vec%0d_oob", k),   oob,       vecs[k].oobv);
      chk($sformatf("vec%0d_ack", k),   ld_ack,    vecs[k].ack);
      chk($sformatf("vec%0d_err", k),   ld_err,    vecs[k].err);
    end

    for (int c = 0; c < 400; c++) begin
      fetch_req = NP'($urandom);
      for (int i = 0; i < NP; i++)
        fetch_pc[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(52, 63))
                                                             : AW'($urandom_range(0, 51));
      ld_en   = ($urandom_range(0, 1) == 1);
      ld_addr = ($urandom_range(0, 3) == 0) ? fetch_pc[AW-1:0] : AW'($urandom_range(0, 63));
      ld_data = IW'($urandom);
      tick();
      check_model("rand");
    end

    // Reset in the middle of a load burst wipes the program
    fetch_req = '0; ld_en = 1'b1; ld_addr = 6'd5; ld_data = VA;
    tick();
    chk("burst_ack", ld_ack, 1'b1);
    rst = 1'b1; ld_addr = 6'd6;
    tick();
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_ack", ld_ack, 1'b0);
    rst = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      ld_addr = AW'($urandom_range(0, 51)); ld_data = IW'($urandom);
      tick(); n++;
      chk("reinit_ack", ld_ack, 1'b0);
      chk("reinit_err", ld_err, 1'b0);
    end
    chk("reinit_latency", n, 52);
    ld_en = 1'b0; fetch_req = 4'h1; fetch_pc = '0; fetch_pc[5:0] = 6'd5;
    tick();
    chk("cleared_pc5", ins_out[20:0], FILL);
    chk("cleared_valid", ins_valid, 4'h1);
    check_model("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
